// File: rtl/gray_window_3x3_pkg.sv
// Shared constants for the 3x3 grayscale window generator: default pixel width,
// window tap indices and the position of the start-of-frame flag in the stream word.
package gray_window_3x3_pkg;

  localparam int PIXWID_DEF = 8;

  // Tap k of the packed window is row dy = k/3, column dx = k%3 (0 = oldest)
  localparam int TAP_TL   = 0;
  localparam int TAP_TC   = 1;
  localparam int TAP_TR   = 2;
  localparam int TAP_ML   = 3;
  localparam int TAP_MC   = 4;
  localparam int TAP_MR   = 5;
  localparam int TAP_BL   = 6;
  localparam int TAP_BC   = 7;
  localparam int TAP_BR   = 8;
  localparam int NUM_TAPS = 9;

  function automatic int sof_bit(input int pixwid);
    return pixwid;
  endfunction

endpackage

// File: rtl/gray_linebuf.sv
// One video line of storage: single write port, combinational read at the same address.
module gray_linebuf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/gray_window_3x3.sv
// Streaming 3x3 neighbourhood generator for grayscale video; emits a window for every
// interior pixel (row>=2, col>=2) one cycle after the pixel is accepted.
module gray_window_3x3
  import gray_window_3x3_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int PIXWID = PIXWID_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         pixelEN,
  input  logic [PIXWID:0]              stream_in,
  output logic [NUM_TAPS*PIXWID-1:0]   window_out,
  output logic                         valid_out,
  output logic                         sof_out
);

  localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SOF_POS = sof_bit(PIXWID);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic              accept;
  logic              sof_in;
  logic [PIXWID-1:0] pix_in;
  logic [COL_W-1:0]  col, cur_col, col_nxt;
  logic [ROW_W-1:0]  row, cur_row, row_nxt;
  logic              interior, first_win;
  logic [PIXWID-1:0] line1_rd, line2_rd;
  logic [PIXWID-1:0] tap [NUM_TAPS];

  assign accept = en & pixelEN;
  assign sof_in = stream_in[SOF_POS];
  assign pix_in = stream_in[PIXWID-1:0];

  // A sof pixel is (0,0) no matter where the counters were
  assign cur_col = sof_in ? '0 : col;
  assign cur_row = sof_in ? '0 : row;

  assign interior  = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
  assign first_win = (cur_row == ROW_W'(2)) && (cur_col == COL_W'(2));

  always_comb begin
    col_nxt = cur_col + COL_W'(1);
    row_nxt = cur_row;
    if (cur_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
    end
  end

  // Line 2 is fed from line 1's old contents at the same column before line 1 is overwritten
  gray_linebuf #(.DEPTH(IMG_W), .WIDTH(PIXWID), .AW(COL_W)) u_line1 (
    .clk   (clk),
    .we    (accept & ~rst),
    .addr  (cur_col),
    .wdata (pix_in),
    .rdata (line1_rd)
  );

  gray_linebuf #(.DEPTH(IMG_W), .WIDTH(PIXWID), .AW(COL_W)) u_line2 (
    .clk   (clk),
    .we    (accept & ~rst),
    .addr  (cur_col),
    .wdata (line1_rd),
    .rdata (line2_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) tap[k] <= '0;
    end else begin
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      if (accept) begin
        tap[TAP_TL] <= tap[TAP_TC];
        tap[TAP_TC] <= tap[TAP_TR];
        tap[TAP_TR] <= line2_rd;
        tap[TAP_ML] <= tap[TAP_MC];
        tap[TAP_MC] <= tap[TAP_MR];
        tap[TAP_MR] <= line1_rd;
        tap[TAP_BL] <= tap[TAP_BC];
        tap[TAP_BC] <= tap[TAP_BR];
        tap[TAP_BR] <= pix_in;
        col       <= col_nxt;
        row       <= row_nxt;
        valid_out <= interior;
        sof_out   <= interior & first_win;
      end
    end
  end

  always_comb begin
    window_out = '0;
    for (int k = 0; k < NUM_TAPS; k++) window_out[PIXWID*k +: PIXWID] = tap[k];
  end

endmodule

// File: tb/tb_gray_window_3x3.sv
// Directed bench for gray_window_3x3 on an 8x4 image; pixel value = base + 16*row + col.
module tb_gray_window_3x3;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic        pixelEN;
  logic [8:0]  stream_in;
  logic [71:0] window_out;
  logic        valid_out;
  logic        sof_out;

  int          errors = 0;
  int          checks = 0;
  int          nvalid = 0;
  logic        last_valid = 1'b0;
  logic [71:0] last_win = '0;

  gray_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIXWID(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pixelEN    (pixelEN),
    .stream_in  (stream_in),
    .window_out (window_out),
    .valid_out  (valid_out),
    .sof_out    (sof_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c, input logic [7:0] base);
    return base + 8'(16 * r + c);
  endfunction

  function automatic logic [71:0] exp_win(input int r, input int c, input logic [7:0] base);
    logic [71:0] w;
    w = '0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        w[8*(3*dy+dx) +: 8] = pix(r - 2 + dy, c - 2 + dx, base);
    return w;
  endfunction

  task automatic px(input logic sof, input int r, input int c, input logic [7:0] base);
    logic        ev;
    logic [71:0] ew;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; pixelEN = 1'b1;
    stream_in = {sof, pix(r, c, base)};
    @(posedge clk);
    #1;
    ev = (r >= 2) && (c >= 2);
    check("valid", 72'(valid_out), 72'(ev));
    check("sof_out", 72'(sof_out), 72'(ev && r == 2 && c == 2));
    if (ev) begin
      ew = exp_win(r, c, base);
      check("window", window_out, ew);
      last_win = ew;
    end
    last_valid = ev;
    if (valid_out) nvalid++;
  endtask

  // Non-accepting cycle; the stream carries a sof word that must be ignored
  task automatic idle(input logic en_v, input logic pen_v);
    @(negedge clk);
    en = en_v; pixelEN = pen_v;
    stream_in = {1'b1, 8'hA5};
    @(posedge clk);
    #1;
    check("idle_valid", 72'(valid_out), 72'(0));
    check("idle_sof", 72'(sof_out), 72'(0));
    if (last_valid) check("idle_hold", window_out, last_win);
  endtask

  task automatic pixels(input logic [7:0] base, input logic first_sof,
                        input int first, input int last, input logic toggle);
    for (int i = first; i < last; i++) begin
      if (toggle) idle(1'b1, 1'b0);
      px(first_sof && i == first, i / W, i % W, base);
    end
  endtask

  task automatic frame(input logic [7:0] base, input logic with_sof, input logic toggle);
    nvalid = 0;
    pixels(base, with_sof, 0, W * H, toggle);
    check("valid_count", 72'(nvalid), 72'(12));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; pixelEN = 1'b1; stream_in = {1'b1, 8'h55};
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 72'(valid_out), 72'(0));
    check("rst_sof", 72'(sof_out), 72'(0));
    check("rst_window", window_out, 72'(0));

    // Plain frame, then a second frame relying on counter wrap instead of sof
    frame(8'h00, 1'b1, 1'b0);
    frame(8'h00, 1'b0, 1'b0);

    // Strobe gaps between every pixel
    frame(8'h00, 1'b1, 1'b1);

    // Restart at what would have been (1,5); new frame values differ from stale ones
    pixels(8'h00, 1'b1, 0, 13, 1'b0);
    frame(8'h80, 1'b1, 1'b0);

    // Reset at (2,4), then a frame with no sof at all
    pixels(8'h00, 1'b1, 0, 20, 1'b0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; pixelEN = 1'b1; stream_in = {1'b0, pix(2, 4, 8'h00)};
    @(posedge clk);
    #1;
    check("rstpulse_valid", 72'(valid_out), 72'(0));
    check("rstpulse_sof", 72'(sof_out), 72'(0));
    check("rstpulse_window", window_out, 72'(0));
    last_valid = 1'b0;
    frame(8'h40, 1'b0, 1'b0);

    // Stage disabled for 5 cycles mid-line after (2,4)
    pixels(8'h00, 1'b1, 0, 21, 1'b0);
    repeat (5) idle(1'b0, 1'b1);
    pixels(8'h00, 1'b0, 21, W * H, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
